// File: rtl/mult_sched_rr.sv
// -----------------------------------------------------------------------------
// mult_sched_rr
//
// Purpose
//   Round-robin scheduler sharing one digit-serial multiplier datapath among
//   R requesters. One request is granted at a time. Its operands are latched
//   and the datapath is cleared. B is then fed two bits per cycle, LSB digit
//   first, for CC cycles. The product is assembled from the datapath output
//   and returned on a valid/ready response channel.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   req_valid  [R]        request valid per requester
//   req_ready  [R]        one-hot accept pulse (combinational, IDLE only)
//   req_a      [R*N]      A operand of requester i at [i*N +: N]
//   req_b      [R*2CC]    B operand of requester i at [i*2CC +: 2CC]
//   rsp_valid             product available
//   rsp_ready             consumer accepts the product
//   rsp_id     [IDW]      requester that owns rsp_data
//   rsp_data   [N+2CC]    unsigned A*B
//   mult_clr              active-high clear of the datapath register
//   mult_a     [N]        datapath A input (zero outside RUN)
//   mult_b     [2]        datapath B digit (zero outside RUN)
//   mult_c     [2N]       datapath output, combinational within the cycle
//
// Configuration
//   MULT_SCHED_ZERO_BYPASS_EN : when defined, a grant with A==0 or B==0 goes
//   straight to DONE with a zero product and never touches the datapath.
// -----------------------------------------------------------------------------
module mult_sched_rr #(
    parameter int N  = 8,
    parameter int CC = 4,
    parameter int R  = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [R-1:0]        req_valid,
    output logic [R-1:0]        req_ready,
    input  logic [R*N-1:0]      req_a,
    input  logic [R*2*CC-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [N+2*CC-1:0]   rsp_data,
    output logic                mult_clr,
    output logic [N-1:0]        mult_a,
    output logic [1:0]          mult_b,
    input  logic [2*N-1:0]      mult_c
);

    localparam int BW = 2 * CC;
    localparam int DW = N + BW;
    localparam int KW = (CC > 1) ? $clog2(CC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [IDW-1:0]  id_q,    id_d;
    logic [N-1:0]    a_q,     a_d;
    logic [BW-1:0]   b_q,     b_d;
    logic [KW-1:0]   k_q,     k_d;
    logic [DW-1:0]   p_q,     p_d;

    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    // Only the top N+2 bits of the datapath output carry product digits.
    logic            unused_c_lo;
    assign unused_c_lo = ^mult_c[N-3:0];

    // Round-robin search: first set req_valid bit at or above ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < R; i++) begin
            cand = IDW'((int'(ptr_q) + i) % R);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case statement can leave one unassigned (no latches).
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        p_d       = p_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        mult_clr  = 1'b1;
        mult_a    = '0;
        mult_b    = '0;

        case (state_q)
            S_IDLE: begin
                // req_ready is combinational, so keep it quiet while reset is held.
                if (grant_vld && rst) begin
                    req_ready[grant_idx] = 1'b1;
                    a_d     = req_a[grant_idx*N +: N];
                    b_d     = req_b[grant_idx*BW +: BW];
                    id_d    = grant_idx;
                    ptr_d   = IDW'((int'(grant_idx) + 1) % R);
                    state_d = S_CLEAR;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
                    if (req_a[grant_idx*N +: N] == '0 || req_b[grant_idx*BW +: BW] == '0) begin
                        p_d     = '0;
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_CLEAR: begin
                k_d     = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                mult_clr = 1'b0;
                mult_a   = a_q;
                mult_b   = b_q[2*k_q +: 2];
                if (k_q == KW'(CC - 1)) begin
                    // Last digit: the datapath now holds every remaining upper bit.
                    p_d[DW-1:BW-2] = mult_c[2*N-1:N-2];
                    state_d        = S_DONE;
                end else begin
                    // Bits N-1:N-2 of the shifted accumulator are final product digit k.
                    p_d[2*k_q +: 2] = mult_c[N-1:N-2];
                    k_d             = k_q + KW'(1);
                end
            end

            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            p_q     <= p_d;
        end
    end

    assign rsp_id   = id_q;
    assign rsp_data = p_q;

endmodule
